// File: rtl/branch_target_table.sv
// Branch target table: DEPTH x D-bit entries with a read-only all-ones sentinel at index 0,
// one-cycle lookups in absolute or PC-relative mode, and write-through forwarding.
module branch_target_table #(
  parameter int D     = 12,
  parameter int A     = 6,
  parameter int DEPTH = 49
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         rd_req,
  input  logic [A-1:0] rd_addr,
  input  logic         rel,
  input  logic [D-1:0] pc,
  output logic [D-1:0] target,
  output logic         target_valid,
  output logic         done,
  output logic         miss
);

  localparam logic [A:0]   DEPTH_W = (A+1)'(DEPTH);
  localparam logic [D-1:0] ONES    = '1;

  logic [D-1:0] mem_q [DEPTH];
  logic [D-1:0] target_q, target_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic         miss_q, miss_d;

  logic         wr_ok_s;
  logic         rd_in_range_s;
  logic         rd_is_sentinel_s;
  logic [D-1:0] entry_s;

  // Entry 0 is never writable, so the sentinel survives any write pattern.
  assign wr_ok_s          = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range_s    = ({1'b0, rd_addr} < DEPTH_W);
  assign rd_is_sentinel_s = (rd_addr == '0);

  // Entry selection with same-edge write forwarding
  always_comb begin
    entry_s = '0;
    if (rd_in_range_s) begin
      if (wr_ok_s && (wr_addr == rd_addr)) begin
        entry_s = wr_data;
      end else begin
        entry_s = mem_q[rd_addr];
      end
    end else begin
      entry_s = '0;
    end
  end

  // Next lookup result; target holds when no request is made
  always_comb begin
    target_d = target_q;
    valid_d  = rd_req;
    done_d   = rd_req && rd_is_sentinel_s;
    miss_d   = rd_req && !rd_in_range_s;
    if (!rd_req) begin
      target_d = target_q;
    end else if (!rd_in_range_s) begin
      target_d = '0;
    end else if (rd_is_sentinel_s) begin
      target_d = ONES;
    end else if (rel) begin
      target_d = pc + entry_s;
    end else begin
      target_d = entry_s;
    end
  end

  // Table storage
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == 0) ? ONES : '0;
      end
    end else if (wr_ok_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Lookup result registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      target_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      miss_q   <= miss_d;
    end
  end

  assign target       = target_q;
  assign target_valid = valid_q;
  assign done         = done_q;
  assign miss         = miss_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Directed self-checking bench for branch_target_table at default parameters.
module tb_branch_target_table;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [11:0] wr_data;
  logic        rd_req;
  logic [5:0]  rd_addr;
  logic        rel;
  logic [11:0] pc;
  logic [11:0] target;
  logic        target_valid;
  logic        done;
  logic        miss;

  int n_cmp = 0;
  int n_err = 0;

  branch_target_table #(.D(12), .A(6), .DEPTH(49)) dut (
    .Clk(Clk), .Reset(Reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rel(rel), .pc(pc),
    .target(target), .target_valid(target_valid), .done(done), .miss(miss)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic we, input logic [5:0] wa, input logic [11:0] wd,
                       input logic rr, input logic [5:0] ra, input logic rl, input logic [11:0] p);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = rr; rd_addr = ra; rel = rl; pc = p;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b0, 6'd0, 12'd0, 1'b0, 6'd0, 1'b0, 12'd0);
    #12;
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: got t=%0d v=%b d=%b m=%b want t=0 v=0 d=0 m=0", target, target_valid, done, miss);
    end
    Reset = 1'b0;
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd1, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_entry1_zero: got t=%0d v=%b d=%b m=%b want t=0 v=1 d=0 m=0", target, target_valid, done, miss);
    end
  endtask

  task automatic test_done();
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd0, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd4095, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL done_abs: got t=%0d v=%b d=%b m=%b want t=4095 v=1 d=1 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd0, 1'b1, 12'd100);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd4095, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL done_rel: got t=%0d v=%b d=%b m=%b want t=4095 v=1 d=1 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b0, 6'd5, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd4095, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL idle_hold: got t=%0d v=%b d=%b m=%b want t=4095 v=0 d=0 m=0", target, target_valid, done, miss);
    end
  endtask

  task automatic test_abs_rel();
    drive(1'b1, 6'd5, 12'd16, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd5, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd16, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL abs5: got t=%0d v=%b d=%b m=%b want t=16 v=1 d=0 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd5, 1'b1, 12'd4090);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd10, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rel5_wrap: got t=%0d v=%b d=%b m=%b want t=10 v=1 d=0 m=0", target, target_valid, done, miss);
    end
  endtask

  task automatic test_forward();
    drive(1'b1, 6'd7, 12'd315, 1'b1, 6'd7, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd315, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL fwd7: got t=%0d v=%b d=%b m=%b want t=315 v=1 d=0 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd7, 1'b1, 12'd5);
    step();
    n_cmp++;
    if (target !== 12'd320) begin
      n_err++;
      $display("FAIL stored7_rel: got t=%0d want t=320", target);
    end
    drive(1'b1, 6'd0, 12'd123, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd0, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd4095, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sentinel_wr0: got t=%0d v=%b d=%b m=%b want t=4095 v=1 d=1 m=0", target, target_valid, done, miss);
    end
    drive(1'b1, 6'd9, 12'd4095, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd9, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd4095, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL ones_not_done: got t=%0d v=%b d=%b m=%b want t=4095 v=1 d=0 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd9, 1'b1, 12'd4);
    step();
    n_cmp++;
    if (target !== 12'd3) begin
      n_err++;
      $display("FAIL rel_neg1: got t=%0d want t=3", target);
    end
  endtask

  task automatic test_miss();
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd50, 1'b1, 12'd77);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL miss50: got t=%0d v=%b d=%b m=%b want t=0 v=1 d=0 m=1", target, target_valid, done, miss);
    end
    drive(1'b1, 6'd48, 12'd200, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b1, 6'd50, 12'd99, 1'b1, 6'd48, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd200, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL last48: got t=%0d v=%b d=%b m=%b want t=200 v=1 d=0 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd49, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL miss49: got t=%0d v=%b d=%b m=%b want t=0 v=1 d=0 m=1", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd50, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL miss50_after_wr: got t=%0d v=%b d=%b m=%b want t=0 v=1 d=0 m=1", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd48, 1'b0, 12'd0);
    step();
    n_cmp++;
    if (target !== 12'd200) begin
      n_err++;
      $display("FAIL last48_kept: got t=%0d want t=200", target);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_t [3];
    logic [5:0]  addrs [3];
    exp_t[0] = 12'd33; exp_t[1] = 12'd22; exp_t[2] = 12'd11;
    addrs[0] = 6'd3;   addrs[1] = 6'd2;   addrs[2] = 6'd1;
    drive(1'b1, 6'd1, 12'd11, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b1, 6'd2, 12'd22, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b1, 6'd3, 12'd33, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'd0, 12'd0, 1'b1, addrs[i], 1'b0, 12'd0);
      step();
      n_cmp++;
      if ({target, target_valid, done, miss} !== {exp_t[i], 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL b2b_%0d: got t=%0d v=%b d=%b m=%b want t=%0d v=1 d=0 m=0", i, target, target_valid, done, miss, exp_t[i]);
      end
    end
    drive(1'b0, 6'd0, 12'd0, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd11, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_drop: got t=%0d v=%b d=%b m=%b want t=11 v=0 d=0 m=0", target, target_valid, done, miss);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] exp_t [6];
    logic [5:0]  addrs [6];
    drive(1'b0, 6'd0, 12'd0, 1'b1, 6'd3, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid} !== {12'd33, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: got t=%0d v=%b want t=33 v=1", target, target_valid);
    end
    #1 Reset = 1'b1;
    #1;
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_clear: got t=%0d v=%b d=%b m=%b want t=0 v=0 d=0 m=0", target, target_valid, done, miss);
    end
    drive(1'b1, 6'd4, 12'd77, 1'b1, 6'd0, 1'b0, 12'd0);
    step();
    n_cmp++;
    if ({target, target_valid, done, miss} !== {12'd0, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL held_reset: got t=%0d v=%b d=%b m=%b want t=0 v=0 d=0 m=0", target, target_valid, done, miss);
    end
    drive(1'b0, 6'd0, 12'd0, 1'b0, 6'd0, 1'b0, 12'd0);
    #1 Reset = 1'b0;
    drive(1'b1, 6'd2, 12'd66, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    drive(1'b0, 6'd0, 12'd0, 1'b0, 6'd0, 1'b0, 12'd0);
    #1 Reset = 1'b1;
    #2 Reset = 1'b0;
    drive(1'b1, 6'd3, 12'd88, 1'b0, 6'd0, 1'b0, 12'd0);
    step();
    addrs[0] = 6'd2; exp_t[0] = 12'd0;
    addrs[1] = 6'd3; exp_t[1] = 12'd88;
    addrs[2] = 6'd1; exp_t[2] = 12'd0;
    addrs[3] = 6'd4; exp_t[3] = 12'd0;
    addrs[4] = 6'd7; exp_t[4] = 12'd0;
    addrs[5] = 6'd48; exp_t[5] = 12'd0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 6'd0, 12'd0, 1'b1, addrs[i], 1'b0, 12'd0);
      step();
      n_cmp++;
      if ({target, target_valid, done, miss} !== {exp_t[i], 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL post_reset_rd%0d: got t=%0d v=%b d=%b m=%b want t=%0d v=1 d=0 m=0", addrs[i], target, target_valid, done, miss, exp_t[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_done();
    test_abs_rel();
    test_forward();
    test_miss();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_table.md
BRANCH_TARGET_TABLE -- requirements
Module: branch_target_table

Interface
REQ-001 The block SHALL have parameter D, default 12, branch target / PC width in bits.
REQ-002 The block SHALL have parameter A, default 6, lookup address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 49, number of implemented entries, with 1 <= DEPTH <= 2**A.
REQ-004 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe for one table entry.
REQ-007 wr_addr  input  A  entry index to write.
REQ-008 wr_data  input  D  value to store.
REQ-009 rd_req  input  1  lookup request.
REQ-010 rd_addr  input  A  entry index to look up.
REQ-011 rel  input  1  lookup mode: 0 = absolute target, 1 = PC-relative offset.
REQ-012 pc  input  D  current PC, sampled with rd_req.
REQ-013 target  output  D  resolved target.
REQ-014 target_valid  output  1  target is valid this cycle.
REQ-015 done  output  1  lookup hit the done sentinel.
REQ-016 miss  output  1  lookup address >= DEPTH.

Function
REQ-017 Storage SHALL be DEPTH entries of D bits; entry 0 SHALL be read-only and permanently hold all-ones (the done sentinel, 4095 at D=12).
REQ-018 Writes SHALL be ignored, with no state change, when wr_addr == 0 or wr_addr >= DEPTH.
REQ-019 Otherwise, with wr_en high at edge n, the block SHALL update entry[wr_addr] to wr_data at edge n.
REQ-020 Lookup latency SHALL be exactly one cycle: rd_req high at edge n SHALL make target, target_valid, done and miss reflect that request after edge n, held until edge n+1.
REQ-021 After any edge with rd_req low, target_valid, done and miss SHALL be 0, and target SHALL hold its previous value.
REQ-022 Absolute mode (rel=0) SHALL set target = entry[rd_addr].
REQ-023 Relative mode (rel=1) SHALL set target = (pc + entry[rd_addr]) mod 2**D, with the entry taken as D-bit two's complement and the carry discarded (e.g. D=12, pc=4, entry=4095 gives 3).
REQ-024 Read-during-write: same-edge wr_en and rd_req to the same writable address SHALL return the new wr_data, as write-through forwarding.
REQ-025 done SHALL be 1 exactly when rd_addr == 0 on a valid lookup.
REQ-026 On done, target SHALL be all-ones regardless of rel or pc.
REQ-027 A non-zero entry that happens to contain all-ones SHALL NOT assert done.
REQ-028 Lookup with rd_addr >= DEPTH SHALL give target = 0 ("hold PC" code, not pc-adjusted), miss = 1, done = 0, target_valid = 1.
REQ-029 miss and done SHALL be mutually exclusive, and both SHALL be 0 whenever target_valid is 0.
REQ-030 No back-pressure: a lookup SHALL be accepted every cycle rd_req is high, so back-to-back lookups give one result per cycle.

Reset
REQ-031 Reset high SHALL immediately, without waiting for Clk, force target = 0, target_valid = 0, done = 0 and miss = 0.
REQ-032 Reset high SHALL immediately set entries 1..DEPTH-1 to 0, with entry 0 remaining all-ones.
REQ-033 While Reset is high, writes and lookups SHALL be ignored.
REQ-034 Reset asserted mid-lookup SHALL discard the in-flight result.
REQ-035 The first lookup SHALL be accepted at the first rising edge after Reset deasserts.

Verification
REQ-036 Reset, then lookup addr 0 with rel=0 and rel=1 (pc=100) -> both cycles give target=4095, done=1, miss=0, target_valid=1.
REQ-037 Write entry 5=16, then lookup 5 with rel=0 -> next cycle target=16; with rel=1, pc=4090 -> target=10 (wrap).
REQ-038 Same-edge write entry 7=315 and lookup 7 -> next cycle target=315; a write to addr 0 then lookup 0 -> target stays 4095.
REQ-039 Lookup addr 50 with DEPTH=49 -> target=0, miss=1, done=0, target_valid=1; a write to addr 50 has no effect.
REQ-040 Write entries 1..3, then issue 3 back-to-back lookups 3,2,1 -> results appear in order on 3 consecutive cycles, with target_valid=0 the cycle after rd_req drops.
REQ-041 Assert Reset between lookup edge and result, and between two writes -> outputs go to 0 asynchronously, and all written entries read back 0 after reset.
